// File: rtl/uart_pkg.sv
// Shared types and field positions for the UART receive/transmit paths.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP1, STOP2} rx_state_e;

  // conf word: [1:0] data bits (5..8), [2] two stop, [3] parity en, [4] odd
  localparam int CONF_DBITS = 0;
  localparam int CONF_STOP2 = 2;
  localparam int CONF_PEN   = 3;
  localparam int CONF_PODD  = 4;

  localparam int PL_PERR = 8;
  localparam int PL_FERR = 9;
  localparam int PL_BRK  = 10;
  localparam int PL_W    = 11;

  // Index of the last data bit for a given data-bits code (00 -> bit 4).
  function automatic logic [2:0] last_bit(input logic [1:0] dbits);
    return 3'd4 + {1'b0, dbits};
  endfunction

endpackage

// File: rtl/uart_rx_deser_if.sv
// Push-side bus from the RX deserializer into the RX FIFO.
interface uart_rx_deser_if;
  import uart_pkg::*;

  logic            fifo_wr;
  logic [PL_W-1:0] fifo_wdata;
  logic            fifo_full;
  logic            overrun;

  modport master (output fifo_wr, fifo_wdata, overrun, input fifo_full);
  modport slave  (input fifo_wr, fifo_wdata, overrun, output fifo_full);

endinterface

// File: rtl/uart_baud_tick.sv
// 16x oversampling tick: one-cycle pulse every div+1 clocks, re-phased by restart.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // div is only sampled on reload, so a mid-frame change lands at the next period.
  always_ff @(posedge clk) begin
    if (!rst_)                      cnt <= '0;
    else if (restart || cnt == '0)  cnt <= div;
    else                            cnt <= cnt - DIV_W'(1);
  end

  assign tick = !restart && (cnt == '0);

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: start qualification, 3-sample majority, parity/stop/break checks.
module uart_rx_deser import uart_pkg::*; #(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             rx_en_i,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic [4:0]       conf_i,
  input  logic             urxd_i,
  output logic             busy_o,
  uart_rx_deser_if.master  fifo
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, prev_q;
  rx_state_e              state;
  logic [3:0]             tcnt;
  logic [2:0]             bit_cnt;
  logic [4:0]             conf_q;
  logic [7:0]             data_q;
  logic                   s7_q, s8_q, par_q, ferr_q, perr_q;
  logic                   tick, maj, at_mid, at_end, push, ferr_now, brk_now;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      sync_q <= '1;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], urxd_i};
      prev_q <= rx_s;
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Counter is held loaded while idle so ticks are phased to the start edge.
  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk     (clk),
    .rst_    (rst_),
    .restart (state == IDLE),
    .div     (baud_div_i),
    .tick    (tick)
  );

  assign maj    = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);
  assign at_mid = tick && (tcnt == 4'd9);
  assign at_end = tick && (tcnt == 4'd15);
  assign push   = rx_en_i && at_mid &&
                  ((state == STOP1 && !conf_q[CONF_STOP2]) || state == STOP2);

  // In STOP2, ferr_q set means the first stop bit was also low.
  assign ferr_now = ferr_q | ~maj;
  assign brk_now  = (data_q == '0) && !(conf_q[CONF_PEN] && par_q) && !maj &&
                    (state == STOP1 || ferr_q);

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state            <= IDLE;
      tcnt             <= '0;
      bit_cnt          <= '0;
      conf_q           <= '0;
      data_q           <= '0;
      s7_q             <= 1'b0;
      s8_q             <= 1'b0;
      par_q            <= 1'b0;
      ferr_q           <= 1'b0;
      perr_q           <= 1'b0;
      fifo.fifo_wr     <= 1'b0;
      fifo.overrun     <= 1'b0;
      fifo.fifo_wdata  <= '0;
    end else begin
      fifo.fifo_wr <= 1'b0;
      fifo.overrun <= 1'b0;
      if (tick) begin
        tcnt <= tcnt + 4'd1;
        if (tcnt == 4'd7) s7_q <= rx_s;
        if (tcnt == 4'd8) s8_q <= rx_s;
      end
      if (push) begin
        fifo.fifo_wr <= !fifo.fifo_full;
        fifo.overrun <= fifo.fifo_full;
        if (!fifo.fifo_full)
          fifo.fifo_wdata <= {brk_now, ferr_now, perr_q, data_q};
      end

      if (!rx_en_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            conf_q  <= conf_i;
            tcnt    <= '0;
            bit_cnt <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            if (prev_q && !rx_s) state <= START;
          end
          START: begin
            if (at_mid && maj) state <= IDLE;
            else if (at_end)   state <= DATA;
          end
          DATA: begin
            if (at_mid) data_q[bit_cnt] <= maj;
            if (at_end) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == last_bit(conf_q[CONF_DBITS +: 2]))
                state <= conf_q[CONF_PEN] ? PAR : STOP1;
            end
          end
          PAR: begin
            if (at_mid) begin
              par_q  <= maj;
              perr_q <= ((^data_q) ^ maj) != conf_q[CONF_PODD];
            end
            if (at_end) state <= STOP1;
          end
          STOP1: begin
            // Single stop: leave at mid-bit so a new start can follow immediately.
            if (at_mid) begin
              ferr_q <= ~maj;
              if (!conf_q[CONF_STOP2]) state <= IDLE;
            end else if (at_end) begin
              state <= STOP2;
            end
          end
          STOP2: if (at_mid) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
- Receive-path serial deserializer of UART_TOP. Sits between the urxd_i pad line and the RX FIFO.
- Oversamples the line at 16x the baud rate, detects and qualifies start bits, and shifts in 5-8 data bits LSB first.
- Checks optional parity and 1 or 2 stop bits.
- Pushes each completed character plus its error flags into the RX FIFO with a one-cycle write pulse.

Parameters:
- DIV_W, 16, width of the baud divisor input.
- SYNC_STAGES, 2, number of input synchronizer flops on urxd_i (minimum 2).

Ports:
- clk  in  1  function clock.
- rst_  in  1  synchronous active-low reset.
- rx_en_i  in  1  receiver enable; low forces IDLE.
- baud_div_i  in  DIV_W  clk cycles per 16x tick, minus 1.
- conf_i  in  5  frame format, encoded as follows:
  - [1:0] data bits: 00=5, 01=6, 10=7, 11=8.
  - [2] two stop bits.
  - [3] parity enable.
  - [4] odd parity.
- urxd_i  in  1  asynchronous serial input; idle high.
- fifo_full_i  in  1  RX FIFO full.
- fifo_wr_o  out  1  one-cycle FIFO push.
- fifo_wdata_o  out  11  push payload:
  - [7:0] data, zero-extended.
  - [8] parity_err.
  - [9] frame_err.
  - [10] break.
- overrun_o  out  1  one-cycle pulse; character dropped because FIFO full.
- busy_o  out  1  high in any state except IDLE.

Behaviour:
- Reset applies on a clk edge while rst_=0. All registers clear, except the synchronizer flops, which reset to 1.
  - fifo_wr_o, overrun_o, busy_o reset to 0; fifo_wdata_o resets to 0; state resets to IDLE.
  - Reset mid-frame abandons the frame with no push.
- Tick generator:
  - Down-counter loads baud_div_i and emits a one-cycle tick when it reaches 0, then reloads. Period is baud_div_i+1 cycles.
  - The counter reloads on leaving IDLE so that ticks are phase-aligned to the start edge.
  - baud_div_i=0 gives a tick every cycle.
- Sampling:
  - The synchronized line is registered once more to form prev.
  - Each bit decision is a 2-of-3 majority over the synchronized value at ticks 7, 8 and 9 of the bit. Tick count 0-15 within the bit.
- State IDLE:
  - On a falling edge (prev=1, sync=0) with rx_en_i=1, go to START.
  - Latch conf_i; the latched value holds for the whole frame.
- State START:
  - At tick 9, the majority result decides:
    - 1 means a false start: return to IDLE with no output.
    - 0 means continue.
  - At tick 15, go to DATA.
- State DATA:
  - Take the majority per bit and shift it in at bit position bit_cnt, LSB first.
  - After N bits go to PAR if parity is enabled, else to STOP1.
- State PAR:
  - Parity error when XOR(data bits, parity bit) differs from conf[4].
    - Even parity expects total ones even, i.e. the XOR is 0.
    - Odd parity expects the XOR to be 1.
- State STOP1:
  - Majority 0 sets frame_err.
  - When the two-stop-bit option is clear, the push happens at tick 9. State returns to IDLE in the same cycle, which allows a back-to-back start during the second half of the stop bit.
- State STOP2 (two stop bits only):
  - Reached at tick 15 of STOP1.
  - Checked the same way as STOP1; it ORs into frame_err.
  - Push happens at its tick 9.
- Break: set when all data bits = 0, parity bit (if present) = 0, and every stop bit = 0. Break implies frame_err=1.
- Push rules:
  - fifo_wr_o pulses in the cycle after the deciding tick.
  - When fifo_full_i=1 in that cycle, fifo_wr_o stays 0 and overrun_o pulses instead. Data is lost.
  - fifo_wdata_o holds its last value between pushes.
- rx_en_i dropping mid-frame returns to IDLE on the next clk with no push.
- A change of baud_div_i mid-frame takes effect at the next reload.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PAR, STOP1, STOP2);
  - conf bit-position constants (CONF_DBITS, CONF_STOP2, CONF_PEN, CONF_PODD);
  - payload bit-position constants (PL_PERR=8, PL_FERR=9, PL_BRK=10).
- One sub-module, uart_baud_tick: divisor counter with a restart input and a tick output. It is reused by the TX serializer.

Test Plan:
- 8N1 golden frame:
  - Stimulus: baud_div_i=1 (32 clk/bit), conf_i=5'b00011, send 0x55.
  - Response: exactly one fifo_wr_o with fifo_wdata_o=11'h055, busy_o low after the push.
- Even-parity error:
  - Stimulus: conf_i=5'b01011, send 0xA5 with parity bit 1.
  - Response: fifo_wdata_o=11'h1A5.
  - Repeat with parity bit 0: fifo_wdata_o=11'h0A5.
- False start:
  - Stimulus: low glitch lasting 3 ticks (6 clk).
  - Response: no push, busy_o back to 0 by tick 10.
  - Then a valid frame carrying 0x3C: push 11'h03C.
- Framing and break:
  - Stop bit driven 0 with data 0x81: push 11'h281.
  - All-zero line for a full 8N1 frame: push 11'h600.
- 5-bit data, two stop bits, back-to-back:
  - Stimulus: conf_i=5'b00100, send 0x1F then 0x0A with no idle gap.
  - Response: two pushes, 11'h01F then 11'h00A, no errors.
- Overrun and reset:
  - fifo_full_i=1 during the push cycle of 0x77: overrun_o pulses once, no fifo_wr_o.
  - rst_=0 for 1 clk during DATA bit 4: no push, all outputs 0, and the next full frame is received correctly.
